// File: rtl/noc_axis_pkg.sv
// Shared defaults and types for the NoC AXI-Stream client blocks.
//   Default bus widths: data, strobe, keep, packet id, destination and user fields.
//   state_t: packet-level output FSM states (IDLE arbitrates, BURST streams one packet).
package noc_axis_pkg;

    localparam int unsigned NOC_DATAW = 128;
    localparam int unsigned NOC_STRBW = 8;
    localparam int unsigned NOC_KEEPW = 8;
    localparam int unsigned NOC_IDW   = 32;
    localparam int unsigned NOC_DESTW = 4;
    localparam int unsigned NOC_USERW = 66;

    typedef enum logic [0:0] {
        IDLE,
        BURST
    } state_t;

endpackage

// File: rtl/client_fifo.sv
// Synchronous FIFO holding one client channel's {tlast, tdata} beats.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata       write strobe and beat; ignored while full
//   pop, rdata        read strobe and head beat (rdata is valid whenever !empty)
//   full, empty       occupancy flags
module client_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + PTR_ONE;
            if (pop && !empty) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/multi_client_axis.sv
// Merges NUM_CH buffered client streams onto one AXI-Stream NoC link at packet granularity.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   client_tdata/tlast/valid/ready    per-channel beat inputs (channel c at slice c)
//   ch_dest                           static NoC destination per channel, sampled at grant
//   axis_client_interface_*           merged AXI-Stream output; tuser carries source channel
module multi_client_axis
    import noc_axis_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATAW      = NOC_DATAW,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DESTW      = NOC_DESTW,
    parameter int unsigned IDW        = NOC_IDW,
    parameter int unsigned STRBW      = NOC_STRBW,
    parameter int unsigned KEEPW      = NOC_KEEPW,
    parameter int unsigned USERW      = NOC_USERW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DATAW-1:0] client_tdata,
    input  logic [NUM_CH-1:0]       client_tlast,
    input  logic [NUM_CH-1:0]       client_valid,
    output logic [NUM_CH-1:0]       client_ready,
    input  logic [NUM_CH*DESTW-1:0] ch_dest,
    input  logic                    axis_client_interface_tready,
    output logic                    axis_client_interface_tvalid,
    output logic                    axis_client_interface_tlast,
    output logic [DESTW-1:0]        axis_client_interface_tdest,
    output logic [IDW-1:0]          axis_client_interface_tid,
    output logic [STRBW-1:0]        axis_client_interface_tstrb,
    output logic [KEEPW-1:0]        axis_client_interface_tkeep,
    output logic [USERW-1:0]        axis_client_interface_tuser,
    output logic [DATAW-1:0]        axis_client_interface_tdata
);

    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned FW  = DATAW + 1;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [FW-1:0]     rdata    [NUM_CH];
    logic [DESTW-1:0]  dest_arr [NUM_CH];

    state_t            state;
    logic              ready_en;
    logic [CHW-1:0]    grant;
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    sel;
    logic [CHW-1:0]    rr_next;
    logic              sel_valid;
    logic [DESTW-1:0]  dest;
    logic [IDW-1:0]    tid_cnt;
    logic              load;

    // client_ready stays low through reset and rises on the first edge after release.
    assign client_ready = ready_en ? ~full : '0;
    assign load         = !axis_client_interface_tvalid || axis_client_interface_tready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c]     = client_valid[c] && client_ready[c];
        assign pop[c]      = (state == BURST) && load && (grant == CHW'(c)) && !empty[c];
        assign dest_arr[c] = ch_dest[c*DESTW +: DESTW];

        client_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (FW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[c]),
            .wdata ({client_tlast[c], client_tdata[c*DATAW +: DATAW]}),
            .pop   (pop[c]),
            .rdata (rdata[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    // Round-robin: first non-empty channel at or after rr_ptr.
    always_comb begin
        logic [CHW-1:0] idx;
        idx       = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CHW'((32'(rr_ptr) + i) % NUM_CH);
            if (!sel_valid && !empty[idx]) begin
                sel_valid = 1'b1;
                sel       = idx;
            end
        end
    end

    assign rr_next = CHW'((32'(sel) + 1) % NUM_CH);

    assign axis_client_interface_tstrb = {STRBW{axis_client_interface_tvalid}};
    assign axis_client_interface_tkeep = {KEEPW{axis_client_interface_tvalid}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                        <= IDLE;
            ready_en                     <= 1'b0;
            grant                        <= '0;
            rr_ptr                       <= '0;
            dest                         <= '0;
            tid_cnt                      <= '0;
            axis_client_interface_tvalid <= 1'b0;
            axis_client_interface_tlast  <= 1'b0;
            axis_client_interface_tdest  <= '0;
            axis_client_interface_tid    <= '0;
            axis_client_interface_tuser  <= '0;
            axis_client_interface_tdata  <= '0;
        end else begin
            ready_en <= 1'b1;
            // A free output register with nothing to load drains to a bubble.
            if (load) axis_client_interface_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant  <= sel;
                        dest   <= dest_arr[sel];
                        rr_ptr <= rr_next;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (load && !empty[grant]) begin
                        axis_client_interface_tvalid <= 1'b1;
                        axis_client_interface_tlast  <= rdata[grant][DATAW];
                        axis_client_interface_tdata  <= rdata[grant][DATAW-1:0];
                        axis_client_interface_tdest  <= dest;
                        axis_client_interface_tid    <= tid_cnt;
                        axis_client_interface_tuser  <= USERW'(grant);
                        if (rdata[grant][DATAW]) begin
                            tid_cnt <= tid_cnt + IDW'(1);
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_client_axis.sv
// Directed bench for multi_client_axis. A second instance with a 2-bit tid runs in lockstep
// on the same inputs so that tid wrap-around is reached after four packets.
module tb_multi_client_axis;

    logic           clk = 1'b0;
    logic           rst;
    logic [511:0]   client_tdata;
    logic [3:0]     client_tlast;
    logic [3:0]     client_valid;
    logic [3:0]     client_ready;
    logic [15:0]    ch_dest;
    logic           tready;
    logic           tvalid;
    logic           tlast;
    logic [3:0]     tdest;
    logic [31:0]    tid;
    logic [7:0]     tstrb;
    logic [7:0]     tkeep;
    logic [65:0]    tuser;
    logic [127:0]   tdata;

    logic [3:0]     s_ready;
    logic           s_tvalid;
    logic           s_tlast;
    logic [3:0]     s_tdest;
    logic [1:0]     s_tid;
    logic [7:0]     s_tstrb;
    logic [7:0]     s_tkeep;
    logic [65:0]    s_tuser;
    logic [127:0]   s_tdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_client_axis dut (
        .clk                          (clk),
        .rst                          (rst),
        .client_tdata                 (client_tdata),
        .client_tlast                 (client_tlast),
        .client_valid                 (client_valid),
        .client_ready                 (client_ready),
        .ch_dest                      (ch_dest),
        .axis_client_interface_tready (tready),
        .axis_client_interface_tvalid (tvalid),
        .axis_client_interface_tlast  (tlast),
        .axis_client_interface_tdest  (tdest),
        .axis_client_interface_tid    (tid),
        .axis_client_interface_tstrb  (tstrb),
        .axis_client_interface_tkeep  (tkeep),
        .axis_client_interface_tuser  (tuser),
        .axis_client_interface_tdata  (tdata)
    );

    multi_client_axis #(.IDW(2)) dut_small (
        .clk                          (clk),
        .rst                          (rst),
        .client_tdata                 (client_tdata),
        .client_tlast                 (client_tlast),
        .client_valid                 (client_valid),
        .client_ready                 (s_ready),
        .ch_dest                      (ch_dest),
        .axis_client_interface_tready (tready),
        .axis_client_interface_tvalid (s_tvalid),
        .axis_client_interface_tlast  (s_tlast),
        .axis_client_interface_tdest  (s_tdest),
        .axis_client_interface_tid    (s_tid),
        .axis_client_interface_tstrb  (s_tstrb),
        .axis_client_interface_tkeep  (s_tkeep),
        .axis_client_interface_tuser  (s_tuser),
        .axis_client_interface_tdata  (s_tdata)
    );

    // Accepted output beats, sampled on the falling edge before the consuming rising edge.
    logic [127:0] q_data [$];
    logic         q_last [$];
    logic [3:0]   q_dest [$];
    logic [31:0]  q_tid  [$];
    logic [65:0]  q_user [$];
    logic [1:0]   q_stid [$];
    int           q_cyc  [$];

    always @(negedge clk) begin
        if (rst && tvalid && tready) begin
            q_data.push_back(tdata);
            q_last.push_back(tlast);
            q_dest.push_back(tdest);
            q_tid.push_back(tid);
            q_user.push_back(tuser);
            q_stid.push_back(s_tid);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int i, input logic [127:0] d,
                              input logic l, input logic [3:0] dst, input logic [31:0] id,
                              input logic [65:0] usr);
        check($sformatf("%s[%0d].tdata", tag, i), q_data[i], d);
        check($sformatf("%s[%0d].tlast", tag, i), 128'(q_last[i]), 128'(l));
        check($sformatf("%s[%0d].tdest", tag, i), 128'(q_dest[i]), 128'(dst));
        check($sformatf("%s[%0d].tid", tag, i), 128'(q_tid[i]), 128'(id));
        check($sformatf("%s[%0d].tuser", tag, i), 128'(q_user[i]), 128'(usr));
    endtask

    task automatic clear_q();
        q_data.delete(); q_last.delete(); q_dest.delete(); q_tid.delete();
        q_user.delete(); q_stid.delete(); q_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [127:0] d, input logic l);
        client_valid[ch]              = 1'b1;
        client_tdata[ch*128 +: 128]   = d;
        client_tlast[ch]              = l;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".tvalid"}, 128'(tvalid), 128'(0));
        check({tag, ".tlast"}, 128'(tlast), 128'(0));
        check({tag, ".tdata"}, tdata, 128'(0));
        check({tag, ".tid"}, 128'(tid), 128'(0));
        check({tag, ".tdest"}, 128'(tdest), 128'(0));
        check({tag, ".tuser"}, 128'(tuser), 128'(0));
        check({tag, ".tstrb"}, 128'(tstrb), 128'(0));
        check({tag, ".tkeep"}, 128'(tkeep), 128'(0));
        check({tag, ".client_ready"}, 128'(client_ready), 128'(0));
    endtask

    initial begin
        int e;
        int k;
        logic acc;

        rst          = 1'b0;
        tready       = 1'b0;
        client_tdata = '0;
        client_tlast = '0;
        client_valid = '0;
        ch_dest      = 16'h9A75; // ch3=9, ch2=A... overwritten per channel below
        ch_dest      = {4'hA, 4'h9, 4'h7, 4'h5};

        // ---- Reset ----
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        #2;
        check("ready_before_first_edge", 128'(client_ready), 128'(0));
        tick();
        check("ready_after_release", 128'(client_ready), 128'(4'hF));
        check("tvalid_after_release", 128'(tvalid), 128'(0));

        // ---- Ch0: 3-beat packet, tdest 5, tid 0 ----
        tready = 1'b1;
        clear_q();
        drive(0, 128'd1, 1'b0); tick(); e = cyc;
        drive(0, 128'd2, 1'b0); tick();
        drive(0, 128'd3, 1'b1); tick();
        client_valid = '0; client_tlast = '0;
        repeat (6) tick();
        check("t1.count", 128'(q_data.size()), 128'(3));
        if (q_data.size() >= 3) begin
            for (int i = 0; i < 3; i++)
                check_beat("t1", i, 128'(i + 1), (i == 2), 4'h5, 32'd0, 66'd0);
            check("t1.first_latency", 128'(q_cyc[0]), 128'(e + 2));
            check("t1.contiguous", 128'(q_cyc[2]), 128'(e + 4));
        end

        // ---- Ch1 and ch2 simultaneous 2-beat packets ----
        clear_q();
        drive(1, 128'h11, 1'b0); drive(2, 128'h21, 1'b0); tick(); e = cyc;
        drive(1, 128'h12, 1'b1); drive(2, 128'h22, 1'b1); tick();
        client_valid = '0; client_tlast = '0;
        repeat (10) tick();
        check("t2.count", 128'(q_data.size()), 128'(4));
        if (q_data.size() >= 4) begin
            check_beat("t2", 0, 128'h11, 1'b0, 4'h7, 32'd1, 66'd1);
            check_beat("t2", 1, 128'h12, 1'b1, 4'h7, 32'd1, 66'd1);
            check_beat("t2", 2, 128'h21, 1'b0, 4'h9, 32'd2, 66'd2);
            check_beat("t2", 3, 128'h22, 1'b1, 4'h9, 32'd2, 66'd2);
            check("t2.ch1_start", 128'(q_cyc[0]), 128'(e + 2));
            check("t2.one_bubble", 128'(q_cyc[2]), 128'(e + 5));
        end

        // ---- Backpressure: ch3 streams a 12-beat packet into a stalled output ----
        clear_q();
        tready = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            drive(3, 128'h300 + 128'(k), (k == 11));
            @(negedge clk);
            acc = client_ready[3];
            tick();
            if (acc) k++;
        end
        // Eight beats fill the FIFO; the ninth sits in the output register.
        check("t3.accepted_while_stalled", 128'(k), 128'(9));
        check("t3.ready_low", 128'(client_ready[3]), 128'(0));
        check("t3.tvalid_held", 128'(tvalid), 128'(1));
        check("t3.tdata_held", tdata, 128'h300);
        check("t3.tlast_held", 128'(tlast), 128'(0));
        check("t3.tstrb", 128'(tstrb), 128'(8'hFF));
        check("t3.tkeep", 128'(tkeep), 128'(8'hFF));
        check("t3.nothing_taken", 128'(q_data.size()), 128'(0));
        tready = 1'b1;
        for (int i = 0; i < 40 && k < 12; i++) begin
            drive(3, 128'h300 + 128'(k), (k == 11));
            @(negedge clk);
            acc = client_ready[3];
            tick();
            if (acc) k++;
        end
        client_valid = '0; client_tlast = '0;
        repeat (15) tick();
        check("t3.accepted_total", 128'(k), 128'(12));
        check("t3.count", 128'(q_data.size()), 128'(12));
        if (q_data.size() >= 12) begin
            for (int i = 0; i < 12; i++)
                check_beat("t3", i, 128'h300 + 128'(i), (i == 11), 4'hA, 32'd3, 66'd3);
            check("t3.small_tid", 128'(q_stid[0]), 128'(3));
        end

        // ---- Starvation mid-packet on ch0; ch1 must wait for tlast ----
        clear_q();
        drive(0, 128'h41, 1'b0); tick(); e = cyc;
        client_valid[0] = 1'b0;
        drive(1, 128'h51, 1'b1); tick();
        client_valid[1] = 1'b0; client_tlast[1] = 1'b0;
        repeat (4) tick();
        check("t4.gap_tvalid", 128'(tvalid), 128'(0));
        drive(0, 128'h42, 1'b0); tick();
        drive(0, 128'h43, 1'b0); tick();
        drive(0, 128'h44, 1'b1); tick();
        client_valid = '0; client_tlast = '0;
        repeat (10) tick();
        check("t4.count", 128'(q_data.size()), 128'(5));
        if (q_data.size() >= 5) begin
            for (int i = 0; i < 4; i++)
                check_beat("t4", i, 128'h41 + 128'(i), (i == 3), 4'h5, 32'd4, 66'd0);
            check_beat("t4", 4, 128'h51, 1'b1, 4'h7, 32'd5, 66'd1);
            check("t4.resume_latency", 128'(q_cyc[1]), 128'(e + 7));
            check("t4.small_tid_wrap", 128'(q_stid[0]), 128'(0));
            check("t4.small_tid_next", 128'(q_stid[4]), 128'(1));
        end

        // ---- Reset in the middle of a ch2 packet ----
        clear_q();
        drive(2, 128'h61, 1'b0); tick();
        drive(2, 128'h62, 1'b0); tick();
        client_valid = '0;
        tick();
        check("t5.mid_packet_valid", 128'(tvalid), 128'(1));
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("t5.async_reset");
        tick();
        rst = 1'b1;
        tick();
        clear_q();
        drive(2, 128'h71, 1'b1); tick();
        client_valid = '0; client_tlast = '0;
        repeat (6) tick();
        check("t5.count", 128'(q_data.size()), 128'(1));
        if (q_data.size() >= 1) begin
            check_beat("t5", 0, 128'h71, 1'b1, 4'h9, 32'd0, 66'd2);
            check("t5.small_tid", 128'(q_stid[0]), 128'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
